// File: rtl/tl_arbiter_2to1.sv
// Two-master to one-slave TileLink-UL arbiter: round-robin on A with PutFull burst lock,
// D responses steered back to their master by the extended source MSB.
module tl_arbiter_2to1 #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int SOURCE_WIDTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     m0_a_valid,
    output logic                     m0_a_ready,
    input  logic [2:0]               m0_a_opcode,
    input  logic [2:0]               m0_a_param,
    input  logic [SOURCE_WIDTH-1:0]  m0_a_source,
    input  logic [ADDRESS_WIDTH-1:0] m0_a_address,
    input  logic [2:0]               m0_a_size,
    input  logic [7:0]               m0_a_mask,
    input  logic [63:0]              m0_a_data,
    input  logic                     m0_a_corrupt,
    output logic                     m0_d_valid,
    input  logic                     m0_d_ready,
    output logic [2:0]               m0_d_opcode,
    output logic [2:0]               m0_d_param,
    output logic [2:0]               m0_d_size,
    output logic [SOURCE_WIDTH-1:0]  m0_d_source,
    output logic                     m0_d_denied,
    output logic                     m0_d_corrupt,
    output logic [63:0]              m0_d_data,

    input  logic                     m1_a_valid,
    output logic                     m1_a_ready,
    input  logic [2:0]               m1_a_opcode,
    input  logic [2:0]               m1_a_param,
    input  logic [SOURCE_WIDTH-1:0]  m1_a_source,
    input  logic [ADDRESS_WIDTH-1:0] m1_a_address,
    input  logic [2:0]               m1_a_size,
    input  logic [7:0]               m1_a_mask,
    input  logic [63:0]              m1_a_data,
    input  logic                     m1_a_corrupt,
    output logic                     m1_d_valid,
    input  logic                     m1_d_ready,
    output logic [2:0]               m1_d_opcode,
    output logic [2:0]               m1_d_param,
    output logic [2:0]               m1_d_size,
    output logic [SOURCE_WIDTH-1:0]  m1_d_source,
    output logic                     m1_d_denied,
    output logic                     m1_d_corrupt,
    output logic [63:0]              m1_d_data,

    output logic                     s_a_valid,
    input  logic                     s_a_ready,
    output logic [2:0]               s_a_opcode,
    output logic [2:0]               s_a_param,
    output logic [2:0]               s_a_size,
    output logic [SOURCE_WIDTH:0]    s_a_source,
    output logic [ADDRESS_WIDTH-1:0] s_a_address,
    output logic [7:0]               s_a_mask,
    output logic [63:0]              s_a_data,
    output logic                     s_a_corrupt,

    input  logic                     s_d_valid,
    output logic                     s_d_ready,
    input  logic [2:0]               s_d_opcode,
    input  logic [2:0]               s_d_param,
    input  logic [2:0]               s_d_size,
    input  logic [SOURCE_WIDTH:0]    s_d_source,
    input  logic                     s_d_denied,
    input  logic                     s_d_corrupt,
    input  logic [63:0]              s_d_data
);

    typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, BURST = 2'd2} state_t;

    state_t     state, state_n;
    logic       grant, grant_n;
    logic       last, last_n;
    logic [2:0] beat, beat_n;
    logic       eff_grant;
    logic       accept;
    logic       is_put;
    logic       d_sel;

    // Only IDLE re-arbitrates; HOLD and BURST keep the latched master.
    always_comb begin
        eff_grant = grant;
        if (state == IDLE) begin
            if (m0_a_valid && !m1_a_valid)      eff_grant = 1'b0;
            else if (m1_a_valid && !m0_a_valid) eff_grant = 1'b1;
            else if (m0_a_valid && m1_a_valid)  eff_grant = ~last;
        end
    end

    always_comb begin
        s_a_valid   = eff_grant ? m1_a_valid   : m0_a_valid;
        s_a_opcode  = eff_grant ? m1_a_opcode  : m0_a_opcode;
        s_a_param   = eff_grant ? m1_a_param   : m0_a_param;
        s_a_size    = eff_grant ? m1_a_size    : m0_a_size;
        s_a_source  = {eff_grant, eff_grant ? m1_a_source : m0_a_source};
        s_a_address = eff_grant ? m1_a_address : m0_a_address;
        s_a_mask    = eff_grant ? m1_a_mask    : m0_a_mask;
        s_a_data    = eff_grant ? m1_a_data    : m0_a_data;
        s_a_corrupt = eff_grant ? m1_a_corrupt : m0_a_corrupt;
        m0_a_ready  = s_a_ready & ~eff_grant;
        m1_a_ready  = s_a_ready & eff_grant;
    end

    assign accept = s_a_valid & s_a_ready;
    assign is_put = (s_a_opcode == 3'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            grant <= 1'b0;
            last  <= 1'b1;
            beat  <= '0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            last  <= last_n;
            beat  <= beat_n;
        end
    end

    always_comb begin
        state_n = state;
        grant_n = grant;
        last_n  = last;
        beat_n  = beat;
        case (state)
            IDLE: begin
                if (s_a_valid) begin
                    if (!s_a_ready) begin
                        state_n = HOLD;
                        grant_n = eff_grant;
                    end else if (is_put) begin
                        state_n = BURST;
                        beat_n  = 3'd1;
                        grant_n = eff_grant;
                    end else begin
                        last_n = eff_grant;
                    end
                end
            end
            HOLD: begin
                if (accept) begin
                    if (is_put) begin
                        state_n = BURST;
                        beat_n  = 3'd1;
                    end else begin
                        state_n = IDLE;
                        last_n  = grant;
                    end
                end
            end
            BURST: begin
                if (accept) begin
                    if (beat == 3'd7) begin
                        state_n = IDLE;
                        beat_n  = '0;
                        last_n  = grant;
                    end else begin
                        beat_n = beat + 3'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // D payload is broadcast; only valid and the ready return are steered.
    assign d_sel        = s_d_source[SOURCE_WIDTH];
    assign m0_d_valid   = s_d_valid & ~d_sel;
    assign m1_d_valid   = s_d_valid & d_sel;
    assign s_d_ready    = d_sel ? m1_d_ready : m0_d_ready;

    assign m0_d_opcode  = s_d_opcode;
    assign m0_d_param   = s_d_param;
    assign m0_d_size    = s_d_size;
    assign m0_d_source  = s_d_source[SOURCE_WIDTH-1:0];
    assign m0_d_denied  = s_d_denied;
    assign m0_d_corrupt = s_d_corrupt;
    assign m0_d_data    = s_d_data;
    assign m1_d_opcode  = s_d_opcode;
    assign m1_d_param   = s_d_param;
    assign m1_d_size    = s_d_size;
    assign m1_d_source  = s_d_source[SOURCE_WIDTH-1:0];
    assign m1_d_denied  = s_d_denied;
    assign m1_d_corrupt = s_d_corrupt;
    assign m1_d_data    = s_d_data;

endmodule

// File: tb/tb_tl_arbiter_2to1.sv
// Self-checking bench for tl_arbiter_2to1: combinational vector table plus
// scoreboarded multi-cycle sequences for arbitration, burst lock, hold and reset.
module tb_tl_arbiter_2to1;

    logic        clk, reset;
    logic        m0_a_valid, m0_a_ready, m1_a_valid, m1_a_ready;
    logic [2:0]  m0_a_opcode, m0_a_param, m0_a_size, m1_a_opcode, m1_a_param, m1_a_size;
    logic [3:0]  m0_a_source, m1_a_source;
    logic [31:0] m0_a_address, m1_a_address;
    logic [7:0]  m0_a_mask, m1_a_mask;
    logic [63:0] m0_a_data, m1_a_data;
    logic        m0_a_corrupt, m1_a_corrupt;
    logic        m0_d_valid, m0_d_ready, m1_d_valid, m1_d_ready;
    logic [2:0]  m0_d_opcode, m0_d_param, m0_d_size, m1_d_opcode, m1_d_param, m1_d_size;
    logic [3:0]  m0_d_source, m1_d_source;
    logic        m0_d_denied, m0_d_corrupt, m1_d_denied, m1_d_corrupt;
    logic [63:0] m0_d_data, m1_d_data;
    logic        s_a_valid, s_a_ready;
    logic [2:0]  s_a_opcode, s_a_param, s_a_size;
    logic [4:0]  s_a_source;
    logic [31:0] s_a_address;
    logic [7:0]  s_a_mask;
    logic [63:0] s_a_data;
    logic        s_a_corrupt;
    logic        s_d_valid, s_d_ready;
    logic [2:0]  s_d_opcode, s_d_param, s_d_size;
    logic [4:0]  s_d_source;
    logic        s_d_denied, s_d_corrupt;
    logic [63:0] s_d_data;

    tl_arbiter_2to1 #(.ADDRESS_WIDTH(32), .SOURCE_WIDTH(4)) dut (
        .clk(clk), .reset(reset),
        .m0_a_valid(m0_a_valid), .m0_a_ready(m0_a_ready), .m0_a_opcode(m0_a_opcode),
        .m0_a_param(m0_a_param), .m0_a_source(m0_a_source), .m0_a_address(m0_a_address),
        .m0_a_size(m0_a_size), .m0_a_mask(m0_a_mask), .m0_a_data(m0_a_data),
        .m0_a_corrupt(m0_a_corrupt), .m0_d_valid(m0_d_valid), .m0_d_ready(m0_d_ready),
        .m0_d_opcode(m0_d_opcode), .m0_d_param(m0_d_param), .m0_d_size(m0_d_size),
        .m0_d_source(m0_d_source), .m0_d_denied(m0_d_denied), .m0_d_corrupt(m0_d_corrupt),
        .m0_d_data(m0_d_data),
        .m1_a_valid(m1_a_valid), .m1_a_ready(m1_a_ready), .m1_a_opcode(m1_a_opcode),
        .m1_a_param(m1_a_param), .m1_a_source(m1_a_source), .m1_a_address(m1_a_address),
        .m1_a_size(m1_a_size), .m1_a_mask(m1_a_mask), .m1_a_data(m1_a_data),
        .m1_a_corrupt(m1_a_corrupt), .m1_d_valid(m1_d_valid), .m1_d_ready(m1_d_ready),
        .m1_d_opcode(m1_d_opcode), .m1_d_param(m1_d_param), .m1_d_size(m1_d_size),
        .m1_d_source(m1_d_source), .m1_d_denied(m1_d_denied), .m1_d_corrupt(m1_d_corrupt),
        .m1_d_data(m1_d_data),
        .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_opcode(s_a_opcode),
        .s_a_param(s_a_param), .s_a_size(s_a_size), .s_a_source(s_a_source),
        .s_a_address(s_a_address), .s_a_mask(s_a_mask), .s_a_data(s_a_data),
        .s_a_corrupt(s_a_corrupt),
        .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_opcode(s_d_opcode),
        .s_d_param(s_d_param), .s_d_size(s_d_size), .s_d_source(s_d_source),
        .s_d_denied(s_d_denied), .s_d_corrupt(s_d_corrupt), .s_d_data(s_d_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  src;
        logic [31:0] addr;
        logic [63:0] data;
        logic [2:0]  op;
    } exp_t;

    // Outputs packed as {s_a_valid, m0_a_ready, m1_a_ready, s_a_source[4], m0_d_valid, m1_d_valid, s_d_ready}
    typedef struct {
        logic       m0v, m1v, sready, sdv, m0dr, m1dr;
        logic [4:0] sdsrc;
        logic [6:0] exp;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[9];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [4:0] src, input logic [31:0] addr, input logic [63:0] data,
                        input logic [2:0] op);
        exp_t e;
        e.src = src; e.addr = addr; e.data = data; e.op = op;
        sb.push_back(e);
    endtask

    // Inputs change at posedge+1; any accepted A beat is scored at posedge+3.
    task automatic step();
        exp_t e;
        #2;
        if (s_a_valid && s_a_ready) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_accept: got source %h expected none", s_a_source);
            end else begin
                e = sb.pop_front();
                check("a_source", 64'(s_a_source), 64'(e.src));
                check("a_address", 64'(s_a_address), 64'(e.addr));
                check("a_data", s_a_data, e.data);
                check("a_opcode", 64'(s_a_opcode), 64'(e.op));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m0(input logic v, input logic [2:0] op, input logic [3:0] src,
                            input logic [31:0] addr, input logic [63:0] data);
        m0_a_valid = v; m0_a_opcode = op; m0_a_source = src; m0_a_address = addr; m0_a_data = data;
    endtask

    task automatic drive_m1(input logic v, input logic [2:0] op, input logic [3:0] src,
                            input logic [31:0] addr, input logic [63:0] data);
        m1_a_valid = v; m1_a_opcode = op; m1_a_source = src; m1_a_address = addr; m1_a_data = data;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive_m0(0, 3'd4, 0, 0, 0);
        drive_m1(0, 3'd4, 0, 0, 0);
        m0_a_param = 0; m1_a_param = 0; m0_a_size = 3'd6; m1_a_size = 3'd6;
        m0_a_mask = 8'hff; m1_a_mask = 8'hff; m0_a_corrupt = 0; m1_a_corrupt = 0;
        m0_d_ready = 0; m1_d_ready = 0; s_a_ready = 0;
        s_d_valid = 0; s_d_opcode = 3'd1; s_d_param = 0; s_d_size = 3'd6;
        s_d_source = 0; s_d_denied = 0; s_d_corrupt = 0; s_d_data = 0;

        vecs[0] = '{m0v:0, m1v:0, sready:1, sdv:0, m0dr:0, m1dr:0, sdsrc:5'h00, exp:7'b0100000};
        vecs[1] = '{m0v:1, m1v:0, sready:1, sdv:0, m0dr:0, m1dr:0, sdsrc:5'h00, exp:7'b1100000};
        vecs[2] = '{m0v:0, m1v:1, sready:1, sdv:0, m0dr:0, m1dr:0, sdsrc:5'h00, exp:7'b1011000};
        vecs[3] = '{m0v:1, m1v:1, sready:1, sdv:0, m0dr:0, m1dr:0, sdsrc:5'h00, exp:7'b1100000};
        vecs[4] = '{m0v:0, m1v:1, sready:0, sdv:0, m0dr:0, m1dr:0, sdsrc:5'h00, exp:7'b1001000};
        vecs[5] = '{m0v:0, m1v:0, sready:0, sdv:1, m0dr:1, m1dr:0, sdsrc:5'h12, exp:7'b0000010};
        vecs[6] = '{m0v:0, m1v:0, sready:0, sdv:1, m0dr:1, m1dr:0, sdsrc:5'h03, exp:7'b0000101};
        vecs[7] = '{m0v:0, m1v:0, sready:0, sdv:0, m0dr:0, m1dr:1, sdsrc:5'h10, exp:7'b0000001};
        vecs[8] = '{m0v:0, m1v:0, sready:0, sdv:1, m0dr:0, m1dr:1, sdsrc:5'h1f, exp:7'b0000011};

        #2;
        check("reset_state", 64'(dut.state), 64'd0);
        check("reset_last_beat", {60'd0, dut.last, dut.beat}, {60'd0, 1'b1, 3'd0});
        check("reset_outputs", {61'd0, s_a_valid, m0_a_ready, m1_a_ready}, 64'd0);
        do_reset();

        // Combinational table, applied from IDLE with last=1, grant=0.
        foreach (vecs[i]) begin
            m0_a_valid = vecs[i].m0v; m1_a_valid = vecs[i].m1v; s_a_ready = vecs[i].sready;
            s_d_valid = vecs[i].sdv; s_d_source = vecs[i].sdsrc;
            m0_d_ready = vecs[i].m0dr; m1_d_ready = vecs[i].m1dr;
            #1;
            check($sformatf("vec%0d", i),
                  64'({s_a_valid, m0_a_ready, m1_a_ready, s_a_source[4], m0_d_valid, m1_d_valid, s_d_ready}),
                  64'(vecs[i].exp));
            if (i == 5) check("d_bp_source", 64'(m1_d_source), 64'd2);
            m0_a_valid = 0; m1_a_valid = 0; s_a_ready = 0; s_d_valid = 0;
            m0_d_ready = 0; m1_d_ready = 0; s_d_source = 0;
            step();
        end

        // Single Get from m0, then 8 read beats returned to m0 only.
        s_a_ready = 1;
        drive_m0(1, 3'd4, 4'h3, 32'h1000, 64'h0);
        push(5'h03, 32'h1000, 64'h0, 3'd4);
        step();
        m0_a_valid = 0;
        m0_d_ready = 1;
        for (int b = 0; b < 8; b++) begin
            s_d_valid = 1; s_d_source = 5'h03; s_d_data = 64'(b);
            #1;
            check("get_resp", {58'd0, m0_d_valid, m1_d_valid, m0_d_source}, {58'd0, 1'b1, 1'b0, 4'h3});
            step();
        end
        s_d_valid = 0; m0_d_ready = 0;

        // Simultaneous Gets after reset alternate m0, m1, m0, m1.
        do_reset();
        drive_m0(1, 3'd4, 4'h1, 32'h2000, 64'h0);
        drive_m1(1, 3'd4, 4'h2, 32'h3000, 64'h0);
        for (int k = 0; k < 2; k++) begin
            push(5'h01, 32'h2000, 64'h0, 3'd4);
            push(5'h12, 32'h3000, 64'h0, 3'd4);
        end
        repeat (4) step();
        m0_a_valid = 0; m1_a_valid = 0;

        // Burst lock: m1 Get raised at m0 beat 2 waits until beat 7 is accepted.
        for (int b = 0; b < 8; b++) begin
            drive_m0(1, 3'd0, 4'h4, 32'h0000_8000, 64'hA0 + 64'(b));
            if (b == 2) drive_m1(1, 3'd4, 4'h5, 32'h4000, 64'h0);
            push(5'h04, 32'h0000_8000, 64'hA0 + 64'(b), 3'd0);
            #1;
            if (b >= 2) check("burst_lock_m1_ready", 64'(m1_a_ready), 64'd0);
            step();
        end
        m0_a_valid = 0;
        push(5'h15, 32'h4000, 64'h0, 3'd4);
        #1;
        check("after_burst_m1_ready", 64'(m1_a_ready), 64'd1);
        step();
        m1_a_valid = 0;

        // Hold under backpressure: m1 stays selected though m0 arrives later.
        s_a_ready = 0;
        drive_m1(1, 3'd4, 4'h7, 32'h5000, 64'h0);
        step();
        drive_m0(1, 3'd4, 4'h8, 32'h6000, 64'h0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("hold_source", 64'(s_a_source), 64'h17);
            check("hold_m0_ready", 64'(m0_a_ready), 64'd0);
            step();
        end
        s_a_ready = 1;
        push(5'h17, 32'h5000, 64'h0, 3'd4);
        step();
        m1_a_valid = 0;
        push(5'h08, 32'h6000, 64'h0, 3'd4);
        step();
        m0_a_valid = 0;

        // Reset after PutFull beat 4, then a tie goes to m0.
        for (int b = 0; b < 5; b++) begin
            drive_m0(1, 3'd0, 4'h6, 32'h0000_9000, 64'hB0 + 64'(b));
            push(5'h06, 32'h0000_9000, 64'hB0 + 64'(b), 3'd0);
            step();
        end
        m0_a_valid = 0;
        #2;
        reset = 1;
        #1;
        check("midreset_state", 64'(dut.state), 64'd0);
        check("midreset_last_beat", {60'd0, dut.last, dut.beat}, {60'd0, 1'b1, 3'd0});
        #1;
        reset = 0;
        drive_m0(1, 3'd4, 4'h9, 32'h7000, 64'h0);
        drive_m1(1, 3'd4, 4'hA, 32'h7100, 64'h0);
        push(5'h09, 32'h7000, 64'h0, 3'd4);
        push(5'h1A, 32'h7100, 64'h0, 3'd4);
        step();
        step();
        m0_a_valid = 0; m1_a_valid = 0;
        step();

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tl_arbiter_2to1.md
Name: tl_arbiter_2to1

Overview:
- Two-master to one-slave TileLink-UL arbiter. It sits directly upstream of the DDR3 native-interface adapter and merges two 64-bit line masters (CPU cache refill and DMA/framebuffer) onto the adapter's single A/D port.
- It extends the source ID with a master-select MSB and keeps each 8-beat PutFull burst unbroken.
- D-channel responses are steered back to their master using that MSB.

Parameters:
ADDRESS_WIDTH, 32, byte address width on all A channels
SOURCE_WIDTH, 4, source width of each master; slave side is SOURCE_WIDTH+1

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
mN_a_valid / mN_a_ready  input / output  1 / 1  master N A handshake (N = 0,1; every mN_* port exists for both)
mN_a_opcode  input  3  4=Get, 0=PutFull
mN_a_param  input  3  forwarded unchanged
mN_a_source  input  SOURCE_WIDTH  master source ID
mN_a_address  input  ADDRESS_WIDTH  64-byte aligned line address
mN_a_size  input  3  forwarded (always 6)
mN_a_mask  input  8  forwarded
mN_a_data  input  64  PutFull beat data
mN_a_corrupt  input  1  forwarded
mN_d_valid / mN_d_ready  output / input  1 / 1  master N D handshake
mN_d_opcode, mN_d_param, mN_d_size  output  3 each  copied from slave D
mN_d_source  output  SOURCE_WIDTH  s_d_source[SOURCE_WIDTH-1:0]
mN_d_denied, mN_d_corrupt  output  1 each  copied from slave D
mN_d_data  output  64  copied from slave D
s_a_valid / s_a_ready  output / input  1 / 1  slave A handshake
s_a_opcode, s_a_param, s_a_size  output  3 each  from granted master
s_a_source  output  SOURCE_WIDTH+1  {grant, granted master source}
s_a_address  output  ADDRESS_WIDTH  from granted master
s_a_mask  output  8  from granted master
s_a_data  output  64  from granted master
s_a_corrupt  output  1  from granted master
s_d_valid / s_d_ready  input / output  1 / 1  slave D handshake
s_d_opcode, s_d_param, s_d_size  input  3 each  slave D fields
s_d_source  input  SOURCE_WIDTH+1  MSB selects master
s_d_denied, s_d_corrupt  input  1 each  slave D flags
s_d_data  input  64  slave D data

Behaviour:
- **Registers:**
  - state ∈ {IDLE, HOLD, BURST}
  - grant (1 bit)
  - last (1 bit, round-robin pointer)
  - beat (3 bits)
- **Reset values:** state=IDLE, grant=0, last=1 (master 0 wins first tie), beat=0.
- **A path:** fully combinational. No added latency on A or D.
  - s_a_valid = mG_a_valid, where G is the effective grant.
  - mG_a_ready = s_a_ready; the other master's a_ready = 0.
- **Effective grant in IDLE (combinational):**
  - Only one master valid: that master.
  - Both valid: ~last.
  - Neither valid: the grant register.
- **Effective grant in HOLD/BURST:** the grant register.
- **Transitions from IDLE:**
  - s_a_valid & ~s_a_ready → HOLD; latch grant.
  - Accepted Get → stay IDLE; last <= G.
  - Accepted PutFull → BURST; beat <= 1; latch grant.
- **HOLD:** selection frozen until accepted, so a request once offered is never withdrawn or switched. On acceptance:
  - Get → IDLE, last <= grant.
  - PutFull → BURST, beat <= 1.
- **BURST:** each accepted beat increments beat.
  - Acceptance at beat==7 → IDLE, beat <= 0, last <= grant.
  - The other master's requests are not visible downstream until then.
- **Beat boundaries:** PutFull is exactly 8 beats (size 6, 64-bit bus); Get is exactly 1 beat. Opcodes other than 0/4 are forwarded and treated as single-beat.
- **D path:**
  - mN_d_valid = s_d_valid & (s_d_source[SOURCE_WIDTH]==N).
  - s_d_ready = mM_d_ready, where M = s_d_source MSB.
  - Payload fields go to both masters unchanged; only valid is steered.
- **D stalls:** D-channel stalls never affect A arbitration.
- **Async reset mid-burst:** returns to IDLE immediately.
  - s_a_valid follows the masters' valid combinationally.
  - The slave shares the same reset, so no partial-burst recovery is required.

Test Plan:
1. **Single Get:** m0 Get, address 0x1000, source 3, m1 idle → same cycle s_a_source=5'h03, s_a_address=0x1000. Slave returns 8 ReadData beats with source 5'h03 → m0_d_valid on each, m0_d_source=3, m1_d_valid=0 throughout.
2. **Simultaneous Gets:** after reset, both masters Get in the same cycle with s_a_ready=1 → cycle 0 grants m0 (s_a_source=5'h0x), cycle 1 grants m1 (5'h1x), then strict alternation while both stay valid.
3. **Burst lock:** m0 PutFull 8 beats, with m1 Get raised at m0 beat 2 → m1_a_ready=0 until m0 beat 7 is accepted. The next cycle grants m1 Get with s_a_source MSB=1.
4. **Hold under backpressure:** s_a_ready=0 while m1 offers a Get; m0 raises valid one cycle later → s_a_source MSB stays 1 until acceptance, and m0 is granted afterwards.
5. **D backpressure:** s_d_valid=1, s_d_source=5'h12, m1_d_ready=0, m0_d_ready=1 → s_d_ready=0, m0_d_valid=0, m1_d_valid=1, m1_d_source=2.
6. **Reset mid-burst:** reset pulsed after PutFull beat 4 → state=IDLE, beat=0, last=1. A following simultaneous request grants m0 first.
